// File: rtl/button_pkg.sv
// Shared types and helpers for the button event decoder.
package button_pkg;

  // Widest button vector the decoder supports.
  localparam int MAX_BUTTONS = 32;
  localparam int MAX_IDX_W   = 5;

  // Auto-repeat tracker states.
  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } rpt_state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [MAX_IDX_W-1:0] prio_enc(input logic [MAX_BUTTONS-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = {MAX_IDX_W{1'b0}};
    for (int i = MAX_BUTTONS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = MAX_IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-FF synchroniser followed by a stable-count debouncer.
// level is the registered debounced state; rise/fall flag the edge at which
// level is about to flip, so the parent can register its pulses in step with it.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             flip_s;

  // The level flips once the input has differed for DEBOUNCE_CYCLES samples.
  assign flip_s = (sync2_q != level_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Synchronise the raw line and count consecutive samples that disagree with the stable level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= {CNT_W{1'b0}};
      end else if (flip_s) begin
        level_q <= sync2_q;
        cnt_q   <= {CNT_W{1'b0}};
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = level_q;
  assign rise  = flip_s & sync2_q;
  assign fall  = flip_s & ~sync2_q;

endmodule

// File: rtl/button_event_decoder.sv
// Front-panel button decoder: debounced levels, press/release pulses,
// lowest-index encode with valid strobe, and auto-repeat of the last pressed button.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS     = 16,
  parameter int IDX_W           = $clog2(NUM_BUTTONS),
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] button_raw,
  input  logic                   repeat_en,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_BUTTONS-1:0] press,
  output logic [NUM_BUTTONS-1:0] release_o,
  output logic [IDX_W-1:0]       button_num,
  output logic                   button_valid
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);

  logic [NUM_BUTTONS-1:0] level_s;
  logic [NUM_BUTTONS-1:0] rise_s;
  logic [NUM_BUTTONS-1:0] fall_s;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (button_raw[g]),
      .level(level_s[g]),
      .rise (rise_s[g]),
      .fall (fall_s[g])
    );
  end

  rpt_state_t             state_q;
  logic [IDX_W-1:0]       trk_idx_q;
  logic [CNT_W-1:0]       rpt_cnt_q;
  logic [NUM_BUTTONS-1:0] press_q;
  logic [NUM_BUTTONS-1:0] release_q;
  logic [IDX_W-1:0]       num_q;
  logic                   valid_q;

  logic                   rpt_hit_s;
  logic [NUM_BUTTONS-1:0] press_d;
  logic [IDX_W-1:0]       edge_idx_s;
  logic [IDX_W-1:0]       num_d;

  // Merge debounce press edges with the auto-repeat pulse and encode both.
  always_comb begin
    rpt_hit_s  = 1'b0;
    press_d    = rise_s;
    edge_idx_s = IDX_W'(prio_enc(MAX_BUTTONS'(rise_s)));
    if ((state_q == TRACK) && repeat_en && (rpt_cnt_q == {CNT_W{1'b0}})) begin
      rpt_hit_s = 1'b1;
      press_d   = rise_s | (NUM_BUTTONS'(1) << trk_idx_q);
    end else begin
      rpt_hit_s = 1'b0;
      press_d   = rise_s;
    end
    num_d = IDX_W'(prio_enc(MAX_BUTTONS'(press_d)));
  end

  // Repeat tracker FSM and registered event outputs; a new press edge always retargets.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      trk_idx_q <= {IDX_W{1'b0}};
      rpt_cnt_q <= {CNT_W{1'b0}};
      press_q   <= {NUM_BUTTONS{1'b0}};
      release_q <= {NUM_BUTTONS{1'b0}};
      num_q     <= {IDX_W{1'b0}};
      valid_q   <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= fall_s;
      valid_q   <= |press_d;
      if (|press_d) begin
        num_q <= num_d;
      end else begin
        num_q <= num_q;
      end
      case (state_q)
        IDLE: begin
          if (|rise_s) begin
            state_q   <= TRACK;
            trk_idx_q <= edge_idx_s;
            rpt_cnt_q <= CNT_W'(REPEAT_DELAY - 1);
          end else begin
            state_q <= IDLE;
          end
        end
        TRACK: begin
          if (|rise_s) begin
            trk_idx_q <= edge_idx_s;
            rpt_cnt_q <= CNT_W'(REPEAT_DELAY - 1);
          end else if (fall_s[trk_idx_q]) begin
            state_q <= IDLE;
          end else if (rpt_hit_s) begin
            rpt_cnt_q <= CNT_W'(REPEAT_PERIOD - 1);
          end else if (repeat_en) begin
            rpt_cnt_q <= rpt_cnt_q - CNT_W'(1);
          end else begin
            rpt_cnt_q <= rpt_cnt_q;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign buttons      = level_s;
  assign press        = press_q;
  assign release_o    = release_q;
  assign button_num   = num_q;
  assign button_valid = valid_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed self-checking bench for button_event_decoder (DEBOUNCE=4, DELAY=10, PERIOD=5).
module tb_button_event_decoder;

  localparam int N     = 16;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     button_raw;
  logic             repeat_en;
  logic [N-1:0]     buttons;
  logic [N-1:0]     press;
  logic [N-1:0]     release_o;
  logic [IDX_W-1:0] button_num;
  logic             button_valid;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] obs_press;
  logic [31:0] obs_rel;
  logic [31:0] acc;
  logic [31:0] num_snap;

  always #5 clk = ~clk;

  button_event_decoder #(
    .NUM_BUTTONS    (N),
    .IDX_W          (IDX_W),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button_raw  (button_raw),
    .repeat_en   (repeat_en),
    .buttons     (buttons),
    .press       (press),
    .release_o   (release_o),
    .button_num  (button_num),
    .button_valid(button_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  // Advance one edge and sample on the following falling edge.
  task automatic next_sample();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    button_raw = 16'h0000;
    repeat_en  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check_eq("rst_buttons", 32'(buttons), 32'h0);
    check_eq("rst_press", 32'(press), 32'h0);
    check_eq("rst_release", 32'(release_o), 32'h0);
    check_eq("rst_num", 32'(button_num), 32'h0);
    check_eq("rst_valid", 32'(button_valid), 32'h0);
    acc = 32'h0;
    for (int k = 0; k < 20; k++) begin
      next_sample();
      acc = acc | 32'(press) | 32'(release_o) | 32'(buttons) | 32'(button_valid);
    end
    check_eq("idle_quiet", acc, 32'h0);

    // Short glitch on button 3 is rejected
    drive_point();
    button_raw = 16'h0008;
    repeat (3) drive_point();
    button_raw = 16'h0000;
    acc = 32'h0;
    for (int k = 0; k < 12; k++) begin
      next_sample();
      acc = acc | 32'(press) | 32'(buttons) | 32'(button_valid);
    end
    check_eq("glitch_reject", acc, 32'h0);

    // Single press/release on button 5
    drive_point();
    button_raw = 16'h0020;
    repeat (5) next_sample();
    check_eq("b5_early_buttons", 32'(buttons), 32'h0);
    next_sample();
    check_eq("b5_buttons", 32'(buttons), 32'h0020);
    check_eq("b5_press", 32'(press), 32'h0020);
    check_eq("b5_num", 32'(button_num), 32'd5);
    check_eq("b5_valid", 32'(button_valid), 32'h1);
    next_sample();
    check_eq("b5_press_gone", 32'(press), 32'h0);
    check_eq("b5_valid_gone", 32'(button_valid), 32'h0);
    check_eq("b5_num_held", 32'(button_num), 32'd5);
    repeat (3) next_sample();
    drive_point();
    button_raw = 16'h0000;
    repeat (5) next_sample();
    check_eq("b5_early_release", 32'(release_o), 32'h0);
    next_sample();
    check_eq("b5_release", 32'(release_o), 32'h0020);
    check_eq("b5_buttons_off", 32'(buttons), 32'h0);
    check_eq("b5_no_press_on_rel", 32'(press), 32'h0);
    next_sample();
    check_eq("b5_release_gone", 32'(release_o), 32'h0);

    // Simultaneous press on buttons 2 and 9
    drive_point();
    button_raw = 16'h0204;
    repeat (6) next_sample();
    check_eq("b2_9_press", 32'(press), 32'h0204);
    check_eq("b2_9_num", 32'(button_num), 32'd2);
    check_eq("b2_9_buttons", 32'(buttons), 32'h0204);
    check_eq("b2_9_valid", 32'(button_valid), 32'h1);
    drive_point();
    button_raw = 16'h0000;
    repeat (10) next_sample();

    // Auto-repeat on button 7
    repeat_en = 1'b1;
    drive_point();
    button_raw = 16'h0080;
    obs_press = 32'h0;
    num_snap  = 32'h0;
    for (int k = 1; k <= 30; k++) begin
      next_sample();
      obs_press[k] = press[7];
      if (k == 16) begin
        num_snap = 32'(button_num) | (32'(button_valid) << 8);
      end
    end
    check_eq("rpt_pattern", obs_press, (32'h1 << 6) | (32'h1 << 16) | (32'h1 << 21) | (32'h1 << 26));
    check_eq("rpt_num_valid", num_snap, 32'h0000_0107);
    drive_point();
    button_raw = 16'h0000;
    obs_press = 32'h0;
    obs_rel   = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      next_sample();
      obs_press[k] = |press;
      obs_rel[k]   = release_o[7];
    end
    check_eq("rpt_after_release", obs_press, 32'h1 << 5);
    check_eq("rpt_release_pulse", obs_rel, 32'h1 << 6);

    // Repeat disabled: only the initial press
    repeat_en = 1'b0;
    drive_point();
    button_raw = 16'h0080;
    obs_press = 32'h0;
    for (int k = 1; k <= 30; k++) begin
      next_sample();
      obs_press[k] = press[7];
    end
    check_eq("norpt_pattern", obs_press, 32'h1 << 6);
    drive_point();
    button_raw = 16'h0000;
    repeat (10) next_sample();

    // Reset while button 4 is held
    drive_point();
    button_raw = 16'h0010;
    repeat (8) next_sample();
    check_eq("b4_held", 32'(buttons), 32'h0010);
    drive_point();
    reset = 1'b1;
    drive_point();
    reset = 1'b0;
    @(negedge clk);
    acc = 32'(buttons) | 32'(press) | 32'(release_o) | 32'(button_num) | 32'(button_valid);
    check_eq("midrst_clear", acc, 32'h0);
    obs_press = 32'h0;
    obs_rel   = 32'h0;
    for (int k = 1; k <= 10; k++) begin
      next_sample();
      obs_press[k] = (press == 16'h0010);
      obs_rel[k]   = |release_o;
    end
    check_eq("midrst_repress", obs_press, 32'h1 << 6);
    check_eq("midrst_no_release", obs_rel, 32'h0);
    check_eq("midrst_num", 32'(button_num), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
